id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode/issue stage sitting between instruction fetch and execute, wrapped around the register file.
//  Decodes the fetched word, drives the register-file read addresses and Jump code.
//  Registers operands, immediate and control into the ID/EX pipeline register.
//  Detects load-use hazards (stall plus bubble) and honours EX branch/jump flushes.
// PARAMETERS
//  DATA_W   32  operand / PC width
//  REG_AW    5  register address width
//  ALUOP_W   4  ALU operation code width (encodings in shared package)
// PORTS
//  clock         in   1       rising-edge clock
//  reset         in   1       asynchronous, active-low reset
//  instr_valid   in   1       fetch presents a valid instr this cycle
//  instr         in   32      fetched instruction word
//  pc_plus4      in   DATA_W  PC+4 of instr
//  rs_data       in   DATA_W  register-file rs read data (combinational, same cycle)
//  rt_data       in   DATA_W  register-file rt read data
//  ex_flush      in   1       EX resolved taken branch/jump; kill instr in ID
//  rs_addr       out  REG_AW  instr[25:21] to register file (combinational)
//  rt_addr       out  REG_AW  instr[20:16] to register file (combinational)
//  jump_code     out  2       to register file: 00 none, 10 j, 11 jal, 01 jr (combinational)
//  stall         out  1       hold PC and IF/ID this cycle (combinational)
//  ex_valid      out  1       EX slot holds a real instruction
//  ex_rs_val     out  DATA_W  registered operands, ex_rt_val likewise
//  ex_imm        out  DATA_W  extended immediate
//  ex_shamt      out  5       shift amount
//  ex_dest       out  REG_AW  destination register
//  ex_alu_op     out  ALUOP_W ALU operation
//  ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch_eq, ex_branch_ne  out 1 each
//  ex_jump       out  2       registered jump_code
//  ex_pc_plus4   out  DATA_W  registered PC+4
//  ex_illegal    out  1       unsupported opcode/funct captured (slot is a bubble)
// BEHAVIOUR
//  Reset: every ex_* output is 0 (ex_valid=0, all enables 0). The block has no other state.
//  Decoding is combinational; the ID/EX register updates on the rising clock edge, giving 1-cycle latency to EX.
//  Supported instructions:
//    R-type funct add 20, sub 22, and 24, or 25, slt 2A, sll 00, srl 02, jr 08.
//    Opcodes addi 08, andi 0C, ori 0D, lui 0F, lw 23, sw 2B, beq 04, bne 05, j 02, jal 03.
//  Immediate: sign-extended for addi/lw/sw/beq/bne; zero-extended for andi/ori; imm<<16 for lui.
//  Destination: rd for R-type, rt for I-type, 31 for jal. Any dest==0 forces ex_reg_write=0.
//  Hazard: stall=1 when all of the following hold: instr_valid; ex_valid; ex_mem_read; ex_dest!=0;
//    ex_dest equals a source the instr actually reads (rs for all but j/jal/lui/sll/srl; rt for R-type, sw, beq, bne).
//    While stalled, the next EX slot is a bubble (ex_valid=0, enables 0) and the ID instr is re-presented next cycle.
//  Flush: ex_flush=1 forces the next EX slot to a bubble and forces stall=0. Flush wins over stall.
//  Bubble: any of !instr_valid, stall, ex_flush, or an illegal instr. ex_illegal=1 only for illegal && instr_valid && !ex_flush.
//  jump_code is 00 whenever instr_valid=0, so the register file never sees a spurious jal.
//  An asserted reset mid-stream clears the EX slot immediately; decode resumes on the first edge after deassertion.
// STRUCTURE
//  Shared package mips_pkg: opcode/funct localparams, ALU op encodings, jump codes (JMP_NONE/J/JAL/JR).
//  One sub-module, id_decoder (purely combinational), handles instr to control/immediate/dest/illegal.
//  The top level holds the hazard logic and the ID/EX register.
// TESTING
//  1. Reset low, then high; drive addi $t0,$zero,5 (0x20080005), valid
//     -> next edge: ex_valid=1, ex_imm=5, ex_dest=8, ex_reg_write=1.
//  2. lw $t1,0($t0) followed by add $t2,$t1,$t0
//     -> stall=1 for exactly one cycle, one bubble, then add issues with ex_dest=10.
//  3. lw $t1 followed by add $t2,$t0,$t0 (no dependence)
//     -> stall stays 0 and there is no bubble.
//  4. ex_flush=1 together with a load-use hazard
//     -> stall=0, next ex_valid=0, then the following instruction issues normally.
//  5. jal 0x0100000 with pc_plus4=0x40
//     -> jump_code=11, ex_dest=31, ex_pc_plus4=0x40. ori $t0,$t0,0xFFFF gives ex_imm=0x0000FFFF.
//  6. Opcode 0x3F -> ex_illegal=1, ex_valid=0. Drive add $zero,... -> ex_reg_write=0. Reset pulse mid-stall -> all ex_* outputs 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS-subset definitions: widths, opcode/funct codes, ALU op and
// jump encodings, and the decode / ID-EX payload structs.
package mips_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned JUMP_W  = 2;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_SRL = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_LUI = 4'd7;

  // Jump codes seen by the register file
  localparam logic [JUMP_W-1:0] JMP_NONE = 2'b00;
  localparam logic [JUMP_W-1:0] JMP_J    = 2'b10;
  localparam logic [JUMP_W-1:0] JMP_JAL  = 2'b11;
  localparam logic [JUMP_W-1:0] JMP_JR   = 2'b01;

  localparam logic [REG_AW-1:0] REG_RA = 5'd31;

  // Decoder result for one instruction word
  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src_imm;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch_eq;
    logic               branch_ne;
    logic [JUMP_W-1:0]  jump;
    logic [REG_AW-1:0]  dest;
    logic [DATA_W-1:0]  imm;
    logic               uses_rs;
    logic               uses_rt;
    logic               illegal;
  } id_ctrl_t;

  // ID/EX pipeline register payload
  typedef struct packed {
    logic               valid;
    logic [DATA_W-1:0]  rs_val;
    logic [DATA_W-1:0]  rt_val;
    logic [DATA_W-1:0]  imm;
    logic [SHAMT_W-1:0] shamt;
    logic [REG_AW-1:0]  dest;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src_imm;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch_eq;
    logic               branch_ne;
    logic [JUMP_W-1:0]  jump;
    logic [DATA_W-1:0]  pc_plus4;
    logic               illegal;
  } ex_slot_t;

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] v);
    return {{(DATA_W-16){1'b0}}, v};
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational instruction decoder.
//   instr : fetched instruction word
//   ctrl  : control, immediate, destination, source usage and illegal flag
// An illegal word yields an all-zero ctrl apart from ctrl.illegal.
module id_decoder
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output id_ctrl_t           ctrl
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [15:0]       imm16;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign imm16  = instr[15:0];

  always_comb begin
    ctrl         = '0;
    ctrl.uses_rs = 1'b1;
    ctrl.dest    = rt;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.dest      = rd;
        ctrl.uses_rt   = 1'b1;
        ctrl.reg_write = 1'b1;
        unique case (funct)
          FN_ADD: ctrl.alu_op = ALU_ADD;
          FN_SUB: ctrl.alu_op = ALU_SUB;
          FN_AND: ctrl.alu_op = ALU_AND;
          FN_OR:  ctrl.alu_op = ALU_OR;
          FN_SLT: ctrl.alu_op = ALU_SLT;
          FN_SLL: begin
            ctrl.alu_op  = ALU_SLL;
            ctrl.uses_rs = 1'b0;
          end
          FN_SRL: begin
            ctrl.alu_op  = ALU_SRL;
            ctrl.uses_rs = 1'b0;
          end
          FN_JR: begin
            ctrl.alu_op    = ALU_ADD;
            ctrl.reg_write = 1'b0;
            ctrl.jump      = JMP_JR;
          end
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        ctrl.alu_op      = ALU_ADD;
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.imm         = sext16(imm16);
      end
      OP_ANDI: begin
        ctrl.alu_op      = ALU_AND;
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.imm         = zext16(imm16);
      end
      OP_ORI: begin
        ctrl.alu_op      = ALU_OR;
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.imm         = zext16(imm16);
      end
      OP_LUI: begin
        ctrl.alu_op      = ALU_LUI;
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.uses_rs     = 1'b0;
        ctrl.imm         = {imm16, 16'h0000};
      end
      OP_LW: begin
        ctrl.alu_op      = ALU_ADD;
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.imm         = sext16(imm16);
      end
      OP_SW: begin
        ctrl.alu_op      = ALU_ADD;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_write   = 1'b1;
        ctrl.uses_rt     = 1'b1;
        ctrl.imm         = sext16(imm16);
      end
      OP_BEQ, OP_BNE: begin
        ctrl.alu_op    = ALU_SUB;
        ctrl.branch_eq = (opcode == OP_BEQ);
        ctrl.branch_ne = (opcode == OP_BNE);
        ctrl.uses_rt   = 1'b1;
        ctrl.imm       = sext16(imm16);
      end
      OP_J, OP_JAL: begin
        // Jump target index travels in the immediate field for EX.
        ctrl.alu_op    = ALU_ADD;
        ctrl.uses_rs   = 1'b0;
        ctrl.imm       = {{(DATA_W-26){1'b0}}, instr[25:0]};
        ctrl.jump      = (opcode == OP_JAL) ? JMP_JAL : JMP_J;
        ctrl.reg_write = (opcode == OP_JAL);
        ctrl.dest      = (opcode == OP_JAL) ? REG_RA : '0;
      end
      default: ctrl.illegal = 1'b1;
    endcase

    // Illegal words carry no control and read no registers.
    if (ctrl.illegal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/issue stage: decodes the fetched word, drives register-file read
// addresses and jump code, detects load-use hazards and holds the ID/EX
// pipeline register.
//   clock, reset        : rising-edge clock, async active-low reset
//   instr_valid/instr   : fetched instruction and its qualifier
//   pc_plus4            : PC+4 of instr
//   rs_data/rt_data     : register-file read data (same cycle)
//   ex_flush            : EX resolved a taken branch/jump
//   rs_addr/rt_addr     : register-file read addresses (combinational)
//   jump_code           : jump code to register file (combinational)
//   stall               : hold PC and IF/ID (combinational)
//   ex_*                : registered ID/EX payload
module id_ex_stage
  import mips_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  pc_plus4,
  input  logic [DATA_W-1:0]  rs_data,
  input  logic [DATA_W-1:0]  rt_data,
  input  logic               ex_flush,
  output logic [REG_AW-1:0]  rs_addr,
  output logic [REG_AW-1:0]  rt_addr,
  output logic [1:0]         jump_code,
  output logic               stall,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_rs_val,
  output logic [DATA_W-1:0]  ex_rt_val,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [4:0]         ex_shamt,
  output logic [REG_AW-1:0]  ex_dest,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src_imm,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_branch_eq,
  output logic               ex_branch_ne,
  output logic [1:0]         ex_jump,
  output logic [DATA_W-1:0]  ex_pc_plus4,
  output logic               ex_illegal
);

  id_ctrl_t dec;
  ex_slot_t ex_d;
  ex_slot_t ex_q;
  logic     load_use_hazard;
  logic     bubble;

  id_decoder u_id_decoder (
    .instr (instr),
    .ctrl  (dec)
  );

  assign rs_addr = instr[25:21];
  assign rt_addr = instr[20:16];

  // Load-use hazard, stall/flush arbitration and next ID/EX contents.
  always_comb begin
    load_use_hazard = instr_valid && ex_q.valid && ex_q.mem_read &&
                      (ex_q.dest != '0) &&
                      ((dec.uses_rs && (rs_addr == ex_q.dest)) ||
                       (dec.uses_rt && (rt_addr == ex_q.dest)));
    // A flush kills the ID instruction, so there is nothing to hold.
    stall     = load_use_hazard && !ex_flush;
    jump_code = instr_valid ? dec.jump : JMP_NONE;
    bubble    = !instr_valid || stall || ex_flush || dec.illegal;

    ex_d         = '0;
    ex_d.illegal = dec.illegal && instr_valid && !ex_flush;
    if (!bubble) begin
      ex_d.valid       = 1'b1;
      ex_d.rs_val      = rs_data;
      ex_d.rt_val      = rt_data;
      ex_d.imm         = dec.imm;
      ex_d.shamt       = instr[10:6];
      ex_d.dest        = dec.dest;
      ex_d.alu_op      = dec.alu_op;
      ex_d.alu_src_imm = dec.alu_src_imm;
      ex_d.reg_write   = dec.reg_write && (dec.dest != '0);
      ex_d.mem_read    = dec.mem_read;
      ex_d.mem_write   = dec.mem_write;
      ex_d.branch_eq   = dec.branch_eq;
      ex_d.branch_ne   = dec.branch_ne;
      ex_d.jump        = dec.jump;
      ex_d.pc_plus4    = pc_plus4;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign ex_valid       = ex_q.valid;
  assign ex_rs_val      = ex_q.rs_val;
  assign ex_rt_val      = ex_q.rt_val;
  assign ex_imm         = ex_q.imm;
  assign ex_shamt       = ex_q.shamt;
  assign ex_dest        = ex_q.dest;
  assign ex_alu_op      = ex_q.alu_op;
  assign ex_alu_src_imm = ex_q.alu_src_imm;
  assign ex_reg_write   = ex_q.reg_write;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_mem_write   = ex_q.mem_write;
  assign ex_branch_eq   = ex_q.branch_eq;
  assign ex_branch_ne   = ex_q.branch_ne;
  assign ex_jump        = ex_q.jump;
  assign ex_pc_plus4    = ex_q.pc_plus4;
  assign ex_illegal     = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, reset-during-stall sequence
// and random stimulus against a behavioural model of the decode/issue rules.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        ex_flush;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [1:0]  jump_code;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic [31:0] ex_imm;
  logic [4:0]  ex_shamt;
  logic [4:0]  ex_dest;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src_imm;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch_eq;
  logic        ex_branch_ne;
  logic [1:0]  ex_jump;
  logic [31:0] ex_pc_plus4;
  logic        ex_illegal;

  always #5 clock = ~clock;

  id_ex_stage dut (
    .clock          (clock),
    .reset          (reset),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .pc_plus4       (pc_plus4),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .ex_flush       (ex_flush),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .jump_code      (jump_code),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .ex_rs_val      (ex_rs_val),
    .ex_rt_val      (ex_rt_val),
    .ex_imm         (ex_imm),
    .ex_shamt       (ex_shamt),
    .ex_dest        (ex_dest),
    .ex_alu_op      (ex_alu_op),
    .ex_alu_src_imm (ex_alu_src_imm),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_branch_eq   (ex_branch_eq),
    .ex_branch_ne   (ex_branch_ne),
    .ex_jump        (ex_jump),
    .ex_pc_plus4    (ex_pc_plus4),
    .ex_illegal     (ex_illegal)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Model of the EX slot
  typedef struct {
    logic        valid;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic [3:0]  alu_op;
    logic        src_imm;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        beq;
    logic        bne;
    logic [1:0]  jump;
    logic [31:0] pc4;
    logic        illegal;
  } slot_t;

  slot_t m_ex;

  function automatic void ref_decode(input logic [31:0] ins, output slot_t s,
                                     output logic legal, output logic urs, output logic urt);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] i16;
    op  = ins[31:26];
    fn  = ins[5:0];
    i16 = ins[15:0];
    s = '{default: 0};
    legal = 1'b1;
    urs = 1'b1;
    urt = 1'b0;
    s.dest = ins[20:16];
    case (op)
      6'h00: begin
        urt = 1'b1;
        s.dest = ins[15:11];
        s.rw = 1'b1;
        case (fn)
          6'h20: s.alu_op = ALU_ADD;
          6'h22: s.alu_op = ALU_SUB;
          6'h24: s.alu_op = ALU_AND;
          6'h25: s.alu_op = ALU_OR;
          6'h2A: s.alu_op = ALU_SLT;
          6'h00: begin s.alu_op = ALU_SLL; urs = 1'b0; end
          6'h02: begin s.alu_op = ALU_SRL; urs = 1'b0; end
          6'h08: begin s.alu_op = ALU_ADD; s.rw = 1'b0; s.jump = 2'b01; end
          default: legal = 1'b0;
        endcase
      end
      6'h08: begin s.alu_op = ALU_ADD; s.src_imm = 1; s.rw = 1; s.imm = {{16{i16[15]}}, i16}; end
      6'h0C: begin s.alu_op = ALU_AND; s.src_imm = 1; s.rw = 1; s.imm = {16'h0, i16}; end
      6'h0D: begin s.alu_op = ALU_OR;  s.src_imm = 1; s.rw = 1; s.imm = {16'h0, i16}; end
      6'h0F: begin s.alu_op = ALU_LUI; s.src_imm = 1; s.rw = 1; s.imm = {i16, 16'h0}; urs = 0; end
      6'h23: begin s.alu_op = ALU_ADD; s.src_imm = 1; s.rw = 1; s.mr = 1; s.imm = {{16{i16[15]}}, i16}; end
      6'h2B: begin s.alu_op = ALU_ADD; s.src_imm = 1; s.mw = 1; urt = 1; s.imm = {{16{i16[15]}}, i16}; end
      6'h04: begin s.alu_op = ALU_SUB; s.beq = 1; urt = 1; s.imm = {{16{i16[15]}}, i16}; end
      6'h05: begin s.alu_op = ALU_SUB; s.bne = 1; urt = 1; s.imm = {{16{i16[15]}}, i16}; end
      6'h02: begin s.jump = 2'b10; urs = 0; s.dest = 5'd0; s.imm = {6'h0, ins[25:0]}; end
      6'h03: begin s.jump = 2'b11; urs = 0; s.dest = 5'd31; s.rw = 1; s.imm = {6'h0, ins[25:0]}; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      s = '{default: 0};
      urs = 1'b0;
      urt = 1'b0;
    end
  endfunction

  // Expected stall / jump_code now and EX slot after the next edge.
  function automatic void ref_eval(input logic [31:0] ins, input logic v, input logic fl,
                                   input logic [31:0] pc, input logic [31:0] rsd,
                                   input logic [31:0] rtd, input slot_t cur,
                                   output logic st, output logic [1:0] jc, output slot_t nx);
    slot_t d;
    logic  legal, urs, urt, hz;
    ref_decode(ins, d, legal, urs, urt);
    hz = v && cur.valid && cur.mr && (cur.dest != 0) &&
         ((urs && ins[25:21] == cur.dest) || (urt && ins[20:16] == cur.dest));
    st = hz && !fl;
    jc = v ? d.jump : 2'b00;
    nx = '{default: 0};
    if (!v || st || fl || !legal) begin
      nx.illegal = v && !fl && !legal;
    end else begin
      nx = d;
      nx.valid = 1'b1;
      nx.rs_val = rsd;
      nx.rt_val = rtd;
      nx.pc4 = pc;
      nx.shamt = ins[10:6];
      if (nx.dest == 0) nx.rw = 1'b0;
    end
  endfunction

  task automatic check_ex(input string tag);
    chk({tag, ".ex_valid"},   32'(ex_valid),       32'(m_ex.valid));
    chk({tag, ".ex_rs_val"},  ex_rs_val,           m_ex.rs_val);
    chk({tag, ".ex_rt_val"},  ex_rt_val,           m_ex.rt_val);
    chk({tag, ".ex_imm"},     ex_imm,              m_ex.imm);
    chk({tag, ".ex_shamt"},   32'(ex_shamt),       32'(m_ex.shamt));
    chk({tag, ".ex_dest"},    32'(ex_dest),        32'(m_ex.dest));
    chk({tag, ".ex_alu_op"},  32'(ex_alu_op),      32'(m_ex.alu_op));
    chk({tag, ".ex_src_imm"}, 32'(ex_alu_src_imm), 32'(m_ex.src_imm));
    chk({tag, ".ex_reg_wr"},  32'(ex_reg_write),   32'(m_ex.rw));
    chk({tag, ".ex_mem_rd"},  32'(ex_mem_read),    32'(m_ex.mr));
    chk({tag, ".ex_mem_wr"},  32'(ex_mem_write),   32'(m_ex.mw));
    chk({tag, ".ex_beq"},     32'(ex_branch_eq),   32'(m_ex.beq));
    chk({tag, ".ex_bne"},     32'(ex_branch_ne),   32'(m_ex.bne));
    chk({tag, ".ex_jump"},    32'(ex_jump),        32'(m_ex.jump));
    chk({tag, ".ex_pc4"},     ex_pc_plus4,         m_ex.pc4);
    chk({tag, ".ex_illegal"}, 32'(ex_illegal),     32'(m_ex.illegal));
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic fl,
                       input logic [31:0] pc, input logic [31:0] rsd, input logic [31:0] rtd);
    instr = ins; instr_valid = v; ex_flush = fl;
    pc_plus4 = pc; rs_data = rsd; rt_data = rtd;
  endtask

  // One fully model-checked cycle; returns the expected stall.
  task automatic cycle(input string tag, input logic [31:0] ins, input logic v, input logic fl,
                       input logic [31:0] pc, input logic [31:0] rsd, input logic [31:0] rtd,
                       output logic st);
    logic [1:0] jc;
    slot_t      nx;
    @(negedge clock);
    drive(ins, v, fl, pc, rsd, rtd);
    #1;
    ref_eval(ins, v, fl, pc, rsd, rtd, m_ex, st, jc, nx);
    chk({tag, ".stall"},     32'(stall),     32'(st));
    chk({tag, ".jump_code"}, 32'(jump_code), 32'(jc));
    chk({tag, ".rs_addr"},   32'(rs_addr),   32'(ins[25:21]));
    chk({tag, ".rt_addr"},   32'(rt_addr),   32'(ins[20:16]));
    @(posedge clock);
    #1;
    m_ex = nx;
    check_ex(tag);
  endtask

  // Directed vectors: one row per cycle, expectations written by hand.
  typedef struct {
    logic [31:0] ins;
    logic        v;
    logic        fl;
    logic [31:0] pc;
    logic        e_stall;
    logic [1:0]  e_jc;
    logic        e_valid;
    logic [4:0]  e_dest;
    logic [31:0] e_imm;
    logic        e_rw;
    logic        e_ill;
  } vec_t;

  localparam logic [31:0] I_ADDI   = 32'h2008_0005; // addi $t0,$zero,5
  localparam logic [31:0] I_LW     = 32'h8D09_0000; // lw   $t1,0($t0)
  localparam logic [31:0] I_ADD_D  = 32'h0128_5020; // add  $t2,$t1,$t0
  localparam logic [31:0] I_ADD_I  = 32'h0108_5020; // add  $t2,$t0,$t0
  localparam logic [31:0] I_JAL    = 32'h0C10_0000; // jal  0x0100000
  localparam logic [31:0] I_ORI    = 32'h3508_FFFF; // ori  $t0,$t0,0xFFFF
  localparam logic [31:0] I_BAD    = 32'hFC00_0000; // opcode 0x3F
  localparam logic [31:0] I_ADD_Z  = 32'h0108_0020; // add  $zero,$t0,$t0

  vec_t vecs[14];

  logic [5:0] fns[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08};
  logic [5:0] ops[8] = '{6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};

  function automatic logic [31:0] rand_instr();
    logic [4:0] r1, r2, r3;
    int k;
    r1 = 5'($urandom_range(0, 3));
    r2 = 5'($urandom_range(0, 3));
    r3 = 5'($urandom_range(0, 3));
    k = $urandom_range(0, 23);
    if (k < 8)       return {6'h00, r1, r2, r3, 5'($urandom), fns[k]};
    else if (k < 16) return {ops[k-8], r1, r2, 16'($urandom)};
    else if (k < 19) return {6'h23, r1, r2, 16'($urandom)};
    else if (k == 19) return {6'h02, 26'($urandom)};
    else if (k == 20) return {6'h03, 26'($urandom)};
    else             return $urandom;
  endfunction

  initial begin
    logic        st;
    logic [31:0] ins, pc;
    logic        v;

    vecs[0]  = '{I_ADDI,  1, 0, 32'h100, 0, 2'b00, 1, 5'd8,  32'd5,          1, 0};
    vecs[1]  = '{I_LW,    1, 0, 32'h104, 0, 2'b00, 1, 5'd9,  32'd0,          1, 0};
    vecs[2]  = '{I_ADD_D, 1, 0, 32'h108, 1, 2'b00, 0, 5'd0,  32'd0,          0, 0};
    vecs[3]  = '{I_ADD_D, 1, 0, 32'h108, 0, 2'b00, 1, 5'd10, 32'd0,          1, 0};
    vecs[4]  = '{I_LW,    1, 0, 32'h10C, 0, 2'b00, 1, 5'd9,  32'd0,          1, 0};
    vecs[5]  = '{I_ADD_I, 1, 0, 32'h110, 0, 2'b00, 1, 5'd10, 32'd0,          1, 0};
    vecs[6]  = '{I_LW,    1, 0, 32'h114, 0, 2'b00, 1, 5'd9,  32'd0,          1, 0};
    vecs[7]  = '{I_ADD_D, 1, 1, 32'h118, 0, 2'b00, 0, 5'd0,  32'd0,          0, 0};
    vecs[8]  = '{I_ADD_D, 1, 0, 32'h11C, 0, 2'b00, 1, 5'd10, 32'd0,          1, 0};
    vecs[9]  = '{I_JAL,   1, 0, 32'h040, 0, 2'b11, 1, 5'd31, 32'h0010_0000,  1, 0};
    vecs[10] = '{I_ORI,   1, 0, 32'h120, 0, 2'b00, 1, 5'd8,  32'h0000_FFFF,  1, 0};
    vecs[11] = '{I_BAD,   1, 0, 32'h124, 0, 2'b00, 0, 5'd0,  32'd0,          0, 1};
    vecs[12] = '{I_ADD_Z, 1, 0, 32'h128, 0, 2'b00, 1, 5'd0,  32'd0,          0, 0};
    vecs[13] = '{I_JAL,   0, 0, 32'h12C, 0, 2'b00, 0, 5'd0,  32'd0,          0, 0};

    m_ex = '{default: 0};
    reset = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    check_ex("reset");
    chk("reset.stall", 32'(stall), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      logic [1:0] jc;
      slot_t      nx;
      string      t;
      t = $sformatf("vec%0d", i);
      @(negedge clock);
      drive(vecs[i].ins, vecs[i].v, vecs[i].fl, vecs[i].pc, 32'h1111_1111, 32'h2222_2222);
      #1;
      chk({t, ".stall"},     32'(stall),     32'(vecs[i].e_stall));
      chk({t, ".jump_code"}, 32'(jump_code), 32'(vecs[i].e_jc));
      ref_eval(vecs[i].ins, vecs[i].v, vecs[i].fl, vecs[i].pc, 32'h1111_1111, 32'h2222_2222,
               m_ex, st, jc, nx);
      @(posedge clock);
      #1;
      m_ex = nx;
      chk({t, ".ex_valid"},   32'(ex_valid),     32'(vecs[i].e_valid));
      chk({t, ".ex_dest"},    32'(ex_dest),      32'(vecs[i].e_dest));
      chk({t, ".ex_imm"},     ex_imm,            vecs[i].e_imm);
      chk({t, ".ex_reg_wr"},  32'(ex_reg_write), 32'(vecs[i].e_rw));
      chk({t, ".ex_illegal"}, 32'(ex_illegal),   32'(vecs[i].e_ill));
      chk({t, ".ex_pc4"},     ex_pc_plus4,       vecs[i].e_valid ? vecs[i].pc : 32'h0);
    end

    // Reset asserted while a load-use stall is pending
    cycle("rst_lw", I_LW, 1'b1, 1'b0, 32'h200, 32'h5, 32'h6, st);
    @(negedge clock);
    drive(I_ADD_D, 1'b1, 1'b0, 32'h204, 32'h7, 32'h8);
    #1;
    chk("rst_mid.stall_before", 32'(stall), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    m_ex = '{default: 0};
    chk("rst_mid.stall_after", 32'(stall), 32'd0);
    check_ex("rst_mid");
    @(posedge clock);
    #1;
    check_ex("rst_hold");
    @(negedge clock);
    reset = 1'b1;
    cycle("rst_resume", I_ADD_D, 1'b1, 1'b0, 32'h204, 32'h7, 32'h8, st);

    // Random stream; a stalled instruction is re-presented until it issues
    st = 1'b0;
    ins = 32'h0;
    pc = 32'h0;
    v = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (!st) begin
        ins = rand_instr();
        v = ($urandom_range(0, 9) != 0);
        pc = $urandom;
      end
      cycle($sformatf("rnd%0d", n), ins, v, ($urandom_range(0, 9) == 0), pc, $urandom, $urandom, st);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
